// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding and opcodes.
// STEP_WAIT is present only when PROG_SEQUENCER_STEP_EN is defined.
package prog_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_IR,
        FETCH_IMM,
        WAIT_IMM,
        ISSUE,
        WAIT_DONE,
        HALT,
        ERROR
`ifdef PROG_SEQUENCER_STEP_EN
        , STEP_WAIT
`endif
    } seq_state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    function automatic logic is_busy(seq_state_t s);
        return !(s == IDLE || s == HALT || s == ERROR);
    endfunction

endpackage

// File: rtl/prog_sequencer_watchdog.sv
// Completion watchdog: counts enabled cycles since the last clear and flags the
// final cycle of the TIMEOUT-cycle window (TIMEOUT must be at least 1).
module seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CW'(1);
        end
    end

    // Expiry on the last waiting cycle makes the state change land exactly TIMEOUT cycles after entry.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/prog_sequencer.sv
// Fetches 9-bit instructions (plus an immediate word for mvi) from a synchronous ROM and
// issues them to a processor one at a time. Define PROG_SEQUENCER_STEP_EN for single-step mode.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
`ifdef PROG_SEQUENCER_STEP_EN
    input  logic          step,
`endif
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic [8:0]    ir,
    output logic [15:0]   din,
    output logic          run,
    input  logic          done,
    output logic          busy,
    output logic          halted,
    output logic          error,
    output logic [15:0]   instr_count
);

    localparam logic [AW-1:0] PC_INC = AW'(1);

    seq_state_t    state;
    seq_state_t    nxt;
    logic [AW-1:0] pc;
    logic          wd_expired;

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (state == ISSUE),
        .enable  (state == WAIT_DONE),
        .expired (wd_expired)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (start) nxt = FETCH;
            FETCH:     nxt = WAIT_IR;
            WAIT_IR: begin
                case (rom_data[8:6])
                    OP_HALT:               nxt = HALT;
                    OP_MVI:                nxt = FETCH_IMM;
                    OP_MV, OP_ADD, OP_SUB: nxt = ISSUE;
                    default:               nxt = ISSUE;
                endcase
            end
            FETCH_IMM: nxt = WAIT_IMM;
            WAIT_IMM:  nxt = ISSUE;
            ISSUE:     nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (done) begin
`ifdef PROG_SEQUENCER_STEP_EN
                    nxt = STEP_WAIT;
`else
                    nxt = FETCH;
`endif
                end else if (wd_expired) begin
                    nxt = ERROR;
                end
            end
            HALT, ERROR: if (start) nxt = FETCH;
`ifdef PROG_SEQUENCER_STEP_EN
            STEP_WAIT: if (step) nxt = FETCH;
`endif
            default:   nxt = IDLE;
        endcase
    end

    // Status and strobe outputs are registered from the next state so they align with it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pc          <= '0;
            rom_addr    <= '0;
            ir          <= '0;
            din         <= '0;
            run         <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            error       <= 1'b0;
            instr_count <= '0;
        end else begin
            state  <= nxt;
            run    <= (nxt == ISSUE);
            busy   <= is_busy(nxt);
            halted <= (nxt == HALT);
            error  <= (nxt == ERROR);
            case (state)
                IDLE, HALT, ERROR: begin
                    if (start) begin
                        pc          <= '0;
                        rom_addr    <= '0;
                        instr_count <= '0;
                    end
                end
                WAIT_IR: begin
                    ir <= rom_data[8:0];
                    pc <= pc + PC_INC;
                    if (nxt == FETCH_IMM) rom_addr <= pc + PC_INC;
                end
                WAIT_IMM: begin
                    din <= rom_data;
                    pc  <= pc + PC_INC;
                end
                WAIT_DONE: begin
                    if (done) begin
                        rom_addr <= pc;
                        if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: a 32-word instance and a 4-word instance exercising pc wrap.
module tb_prog_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn, start, done, start_b, done_b;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data, din, instr_count;
    logic [8:0]  ir;
    logic        run, busy, halted, error;
    logic [1:0]  rom_addr_b;
    logic [15:0] rom_data_b, din_b, instr_count_b;
    logic [8:0]  ir_b;
    logic        run_b, busy_b, halted_b, error_b;

    logic [15:0] rom_a [32];
    logic [15:0] rom_b [4];
    int checks = 0;
    int errors = 0;

    prog_sequencer #(.AW(5), .TIMEOUT(15)) dut_a (
        .clock(clock), .resetn(resetn), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .ir(ir), .din(din), .run(run), .done(done), .busy(busy), .halted(halted), .error(error),
        .instr_count(instr_count)
    );

    prog_sequencer #(.AW(2), .TIMEOUT(15)) dut_b (
        .clock(clock), .resetn(resetn), .start(start_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .ir(ir_b), .din(din_b), .run(run_b), .done(done_b), .busy(busy_b), .halted(halted_b),
        .error(error_b), .instr_count(instr_count_b)
    );

    always @(posedge clock) begin
        rom_data   <= rom_a[rom_addr];
        rom_data_b <= rom_b[rom_addr_b];
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(rom_addr, 0, {tag, "_rom_addr"});
        chk(ir, 0, {tag, "_ir"});
        chk(din, 0, {tag, "_din"});
        chk(run, 0, {tag, "_run"});
        chk(busy, 0, {tag, "_busy"});
        chk(halted, 0, {tag, "_halted"});
        chk(error, 0, {tag, "_error"});
        chk(instr_count, 0, {tag, "_count"});
    endtask

    task automatic fill_rom_a;
        for (int i = 0; i < 32; i++) rom_a[i] = 16'h01C0;
    endtask

    task automatic pulse_start(input bit b);
        @(negedge clock);
        if (b) start_b = 1'b1; else start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start_b = 1'b0;
    endtask

    // reply: 0 = never answer, 1 = done two cycles after run, 2 = done only alongside run
    task automatic expect_run(input bit b, input logic [8:0] e_ir, input logic [15:0] e_din,
                              input bit chk_din, input logic [4:0] e_addr, input int reply,
                              input string tag);
        int k = 0;
        while ((b ? run_b : run) !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        chk(b ? run_b : run, 1, {tag, "_run"});
        chk(b ? ir_b : ir, e_ir, {tag, "_ir"});
        if (chk_din) chk(b ? din_b : din, e_din, {tag, "_din"});
        chk(b ? rom_addr_b : rom_addr, e_addr, {tag, "_addr"});
        if (reply == 2) begin
            if (b) done_b = 1'b1; else done = 1'b1;
        end
        @(negedge clock);
        done = 1'b0;
        done_b = 1'b0;
        chk(b ? run_b : run, 0, {tag, "_single"});
        if (reply == 1) begin
            @(negedge clock);
            if (b) done_b = 1'b1; else done = 1'b1;
            @(negedge clock);
            done = 1'b0;
            done_b = 1'b0;
        end
    endtask

    task automatic wait_halted(input string tag);
        int k = 0;
        while (halted !== 1'b1 && k < 60) begin
            @(negedge clock);
            k++;
        end
        chk(halted, 1, {tag, "_halted"});
        chk(busy, 0, {tag, "_busy"});
        chk(error, 0, {tag, "_error"});
    endtask

    initial begin
        int k;
        resetn = 1'b0; start = 1'b0; done = 1'b0; start_b = 1'b0; done_b = 1'b0;
        fill_rom_a();
        rom_b[0] = 16'hA081; rom_b[1] = 16'h00C1; rom_b[2] = 16'h0008; rom_b[3] = 16'h0040;
        @(negedge clock);
        @(negedge clock);
        chk_reset("init");
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        chk({busy, run, halted}, 0, "idle_hold");

        // mvi r0, #5 then halt
        fill_rom_a();
        rom_a[0] = 16'h0040; rom_a[1] = 16'h0005; rom_a[2] = 16'h01C0;
        pulse_start(1'b0);
        expect_run(1'b0, 9'h040, 16'h0005, 1'b1, 5'd1, 1, "mvi");
        wait_halted("mvi_end");
        chk(instr_count, 1, "mvi_count");
        chk(ir, 9'h1C0, "mvi_halt_ir");

        // mv, add, sub, halt restarted from HALT, with a start pulse while busy
        fill_rom_a();
        rom_a[0] = 16'h0008; rom_a[1] = 16'h0081; rom_a[2] = 16'h00C1; rom_a[3] = 16'h01C0;
        pulse_start(1'b0);
        expect_run(1'b0, 9'h008, 16'h0, 1'b0, 5'd0, 1, "seq0");
        expect_run(1'b0, 9'h081, 16'h0, 1'b0, 5'd1, 1, "seq1");
        pulse_start(1'b0);
        expect_run(1'b0, 9'h0C1, 16'h0, 1'b0, 5'd2, 1, "seq2");
        wait_halted("seq_end");
        chk(instr_count, 3, "seq_count");
        chk(rom_addr, 3, "seq_last_addr");

        // no done: watchdog timeout, done alongside run is ignored
        fill_rom_a();
        rom_a[0] = 16'h0081;
        pulse_start(1'b0);
        expect_run(1'b0, 9'h081, 16'h0, 1'b0, 5'd0, 2, "wd");
        k = 1;
        while (error !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        chk(k, 16, "wd_cycles");
        chk(error, 1, "wd_error");
        chk(busy, 0, "wd_busy");
        chk(instr_count, 0, "wd_count");
        pulse_start(1'b0);
        expect_run(1'b0, 9'h081, 16'h0, 1'b0, 5'd0, 1, "wd_restart");
        wait_halted("wd_restart_end");
        chk(instr_count, 1, "wd_restart_count");

        // asynchronous reset in WAIT_DONE of the second instruction
        fill_rom_a();
        rom_a[0] = 16'h0081; rom_a[1] = 16'h00C1; rom_a[2] = 16'h01C0;
        pulse_start(1'b0);
        expect_run(1'b0, 9'h081, 16'h0, 1'b0, 5'd0, 1, "rst0");
        expect_run(1'b0, 9'h0C1, 16'h0, 1'b0, 5'd1, 0, "rst1");
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        chk({busy, run, halted, error}, 0, "post_rst_idle");
        pulse_start(1'b0);
        expect_run(1'b0, 9'h081, 16'h0, 1'b0, 5'd0, 1, "rst_again0");
        expect_run(1'b0, 9'h0C1, 16'h0, 1'b0, 5'd1, 1, "rst_again1");
        wait_halted("rst_again_end");
        chk(instr_count, 2, "rst_again_count");

        // AW=2: mvi in the last word takes its immediate from word 0 and pc wraps
        pulse_start(1'b1);
        expect_run(1'b1, 9'h081, 16'h0, 1'b0, 5'd0, 1, "wrap_add");
        expect_run(1'b1, 9'h0C1, 16'h0, 1'b0, 5'd1, 1, "wrap_sub");
        expect_run(1'b1, 9'h008, 16'h0, 1'b0, 5'd2, 1, "wrap_mv");
        expect_run(1'b1, 9'h040, 16'hA081, 1'b1, 5'd0, 1, "wrap_mvi");
        expect_run(1'b1, 9'h0C1, 16'hA081, 1'b1, 5'd1, 1, "wrap_next");
        chk(instr_count_b, 5, "wrap_count");
        chk({busy_b, halted_b, error_b}, 3'b100, "wrap_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter AW, default 5: program ROM address width (2**AW words).
REQ-002 Parameter TIMEOUT, default 15: max cycles to wait for done after issue.
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begin execution from address 0.
REQ-006 rom_addr  output  AW  program ROM word address.
REQ-007 rom_data  input  16  ROM read data, valid exactly one cycle after rom_addr is presented (synchronous ROM).
REQ-008 ir  output  9  instruction to processor, format III XXX YYY (rom_data[8:0]).
REQ-009 din  output  16  immediate word for mvi.
REQ-010 run  output  1  single-cycle issue strobe to processor.
REQ-011 done  input  1  processor completion pulse.
REQ-012 busy  output  1  high in any state other than IDLE, HALT, ERROR.
REQ-013 halted  output  1  high in HALT.
REQ-014 error  output  1  high in ERROR.
REQ-015 instr_count  output  16  count of instructions completed since start.

Function
REQ-016 States SHALL be IDLE, FETCH, WAIT_IR, FETCH_IMM, WAIT_IMM, ISSUE, WAIT_DONE, HALT, ERROR.
REQ-017 IDLE: start -> FETCH with pc cleared to 0 and instr_count cleared to 0; otherwise hold.
REQ-018 FETCH drives rom_addr=pc then -> WAIT_IR; WAIT_IR latches rom_data[8:0] into ir and increments pc.
REQ-019 Decode in WAIT_IR: opcode 111 -> HALT; opcode 001 (mvi) -> FETCH_IMM; any other -> ISSUE.
REQ-020 FETCH_IMM drives rom_addr=pc -> WAIT_IMM; WAIT_IMM latches rom_data into din, increments pc, -> ISSUE.
REQ-021 ISSUE asserts run for exactly one cycle with ir/din stable, -> WAIT_DONE; ir and din SHALL stay stable until done.
REQ-022 WAIT_DONE: done -> instr_count+1, -> FETCH; a done arriving in the same cycle as run SHALL be ignored.
REQ-023 Watchdog counter SHALL clear on ISSUE, count in WAIT_DONE; reaching TIMEOUT without done -> ERROR.
REQ-024 pc SHALL wrap from 2**AW-1 to 0 without error; an mvi in the last word takes its immediate from address 0.
REQ-025 instr_count SHALL saturate at 16'hFFFF.
REQ-026 HALT and ERROR SHALL hold all outputs; start in either -> FETCH with pc=0 and instr_count=0.
REQ-027 start while busy SHALL be ignored; done outside WAIT_DONE SHALL be ignored.
REQ-028 run SHALL never be asserted on two consecutive cycles.

Reset
REQ-029 Asynchronous assertion of resetn low SHALL force IDLE, pc=0, rom_addr=0, ir=0, din=0, run=0, busy=0, halted=0, error=0, instr_count=0, watchdog=0, including mid-instruction.
REQ-030 Deassertion SHALL take effect on the next rising clock edge; no run is issued before a new start.

Configuration
REQ-031 Macro PROG_SEQUENCER_STEP_EN, when defined, SHALL add input step (1 bit) and a STEP_WAIT state between FETCH completion of the previous instruction and the next FETCH, leaving only on a step pulse; start still enters FETCH directly.
REQ-032 Without PROG_SEQUENCER_STEP_EN the step port and STEP_WAIT SHALL not exist and sequencing is free-running.

Structure
REQ-033 A shared package SHALL hold the state enumeration and opcode constants (MV=000, MVI=001, ADD=010, SUB=011, HALT=111).
REQ-034 The watchdog SHALL be a sub-module named seq_watchdog (clear, enable, TIMEOUT parameter, expired output); all else stays in prog_sequencer.

Verification
REQ-035 ROM {0: mvi r0 (001000000), 1: 16'h0005, 2: halt (111000000)}, start, done 2 cycles after run -> one run with ir=9'b001000000, din=16'h0005, then halted=1, instr_count=1.
REQ-036 ROM {mv r1,r0; add r0,r1; sub r0,r1; halt} -> three run pulses with ir in order, instr_count=3, rom_addr sequence 0,1,2,3.
REQ-037 Never assert done after first run -> error=1 exactly TIMEOUT cycles after WAIT_DONE entry; start then restarts from address 0.
REQ-038 resetn low during WAIT_DONE of second instruction -> all outputs zero immediately; start after release fetches address 0.
REQ-039 AW=2, ROM {add, sub, mv, mvi} with immediate at address 0 -> din = word 0 contents, pc wraps, no error.
REQ-040 With PROG_SEQUENCER_STEP_EN: no second run until step pulsed; one step -> exactly one additional run.
